mem_stall_ctrl: RTL and testbench

- Pipeline freeze/flush sequencer for the 5-stage MIPS core.
- Watches the MEM-stage cache access and the ID/EX load-use hazard. Drives the `freeze` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the ID/EX bubble.
- Owns the main-memory request/grant/ready handshake for cache line fills on read miss and for write-through stores (SB/SW).

---
 rtl/mips_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 22 ++
 rtl/mem_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stall_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the MIPS pipeline control blocks
package mips_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        FILL    = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        RESUME  = 3'd6
    } stall_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync clear and async active-low reset
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - pipeline freeze/flush sequencer and main-memory handshake for MEM-stage misses
module mem_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             cache_hit,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             mem_gnt,
    input  logic             mem_ready,
    output logic             freeze_if_id,
    output logic             freeze_id_ex,
    output logic             freeze_ex_mem,
    output logic             freeze_mem_wb,
    output logic             bubble_id_ex,
    output logic             mem_req,
    output logic             mem_we,
    output logic             fill_en,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    stall_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              miss;
    logic              in_wait;
    logic              wait_expired;
    logic              frz;
    logic              lu;

    assign miss         = (mem_read & ~cache_hit) | mem_write;
    assign in_wait      = (state == RD_WAIT) || (state == WR_WAIT);
    // wait_cnt holds the number of completed wait cycles, so this is the TIMEOUT_CYCLES-th one
    assign wait_expired = in_wait && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        state <= WR_REQ;
                    end else if (miss) begin
                        state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        state <= FILL;
                    end else if (wait_expired) begin
                        state       <= RD_REQ;
                        timeout_err <= 1'b1;
                    end
                end
                FILL: state <= RESUME;
                WR_REQ: begin
                    if (mem_gnt) begin
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        state <= RESUME;
                    end else if (wait_expired) begin
                        state       <= WR_REQ;
                        timeout_err <= 1'b1;
                    end
                end
                RESUME:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst_b so the Mealy freeze terms also drop while reset is held
    assign frz = rst_b & (((state != IDLE) && (state != RESUME)) | ((state == IDLE) & miss));
    assign lu  = rst_b & ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign freeze_if_id  = frz | lu;
    assign freeze_id_ex  = frz;
    assign freeze_ex_mem = frz;
    assign freeze_mem_wb = frz;
    assign bubble_id_ex  = lu & ~frz;

    assign mem_req = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we  = (state == WR_REQ);
    assign fill_en = (state == FILL);

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (~in_wait),
        .en    (in_wait),
        .count (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (1'b0),
        .en    (frz),
        .count (stall_count)
    );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - directed self-checking bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        cache_hit = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  ex_rt = '0;
    logic        ex_mem_read = 1'b0;
    logic        mem_gnt = 1'b0;
    logic        mem_ready = 1'b0;
    logic        freeze_if_id;
    logic        freeze_id_ex;
    logic        freeze_ex_mem;
    logic        freeze_mem_wb;
    logic        bubble_id_ex;
    logic        mem_req;
    logic        mem_we;
    logic        fill_en;
    logic        timeout_err;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    mem_stall_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .cache_hit     (cache_hit),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_rt         (ex_rt),
        .ex_mem_read   (ex_mem_read),
        .mem_gnt       (mem_gnt),
        .mem_ready     (mem_ready),
        .freeze_if_id  (freeze_if_id),
        .freeze_id_ex  (freeze_id_ex),
        .freeze_ex_mem (freeze_ex_mem),
        .freeze_mem_wb (freeze_mem_wb),
        .bubble_id_ex  (bubble_id_ex),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .fill_en       (fill_en),
        .timeout_err   (timeout_err),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    // {freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb, bubble_id_ex}
    function automatic logic [4:0] frz_vec();
        return {freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb, bubble_id_ex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then stay 1 time unit clear of the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inputs are changed, then outputs sampled 1 unit later
    task automatic settle();
        #1;
    endtask

    initial begin
        // reset state
        settle();
        chk("rst_frz", 32'(frz_vec()), 32'h00);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_cnt", 32'(stall_count), 32'h0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        // load hit: no stall, no memory traffic
        mem_read = 1'b1; cache_hit = 1'b1;
        settle();
        chk("hit_frz", 32'(frz_vec()), 32'h00);
        tick();
        chk("hit_req", 32'(mem_req), 32'h0);
        chk("hit_cnt", 32'(stall_count), 32'h0);

        // read miss: gnt on first REQ cycle, ready on third wait cycle
        cache_hit = 1'b0; mem_gnt = 1'b1;
        settle();
        chk("rm_idle_frz", 32'(frz_vec()), 32'h1E);
        chk("rm_idle_req", 32'(mem_req), 32'h0);
        tick();
        chk("rm_req", 32'(mem_req), 32'h1);
        chk("rm_req_we", 32'(mem_we), 32'h0);
        tick();
        mem_gnt = 1'b0;
        settle();
        chk("rm_wait_req", 32'(mem_req), 32'h0);
        tick();
        tick();
        mem_ready = 1'b1;
        settle();
        chk("rm_wait3_frz", 32'(frz_vec()), 32'h1E);
        tick();
        mem_ready = 1'b0; cache_hit = 1'b1;
        settle();
        chk("rm_fill_en", 32'(fill_en), 32'h1);
        chk("rm_fill_frz", 32'(frz_vec()), 32'h1E);
        tick();
        chk("rm_resume_frz", 32'(frz_vec()), 32'h00);
        chk("rm_resume_fill", 32'(fill_en), 32'h0);
        chk("rm_cnt", 32'(stall_count), 32'd6);
        tick();
        chk("rm_idle_hit_frz", 32'(frz_vec()), 32'h00);
        mem_read = 1'b0; cache_hit = 1'b0;
        tick();

        // write-through store: gnt on second REQ cycle, ready on first wait cycle
        mem_write = 1'b1;
        settle();
        chk("st_idle_frz", 32'(frz_vec()), 32'h1E);
        tick();
        chk("st_req", 32'(mem_req), 32'h1);
        chk("st_we", 32'(mem_we), 32'h1);
        tick();
        mem_gnt = 1'b1;
        settle();
        chk("st_req2_we", 32'(mem_we), 32'h1);
        tick();
        mem_gnt = 1'b0; mem_ready = 1'b1;
        settle();
        chk("st_wait_frz", 32'(frz_vec()), 32'h1E);
        chk("st_wait_req", 32'(mem_req), 32'h0);
        chk("st_wait_fill", 32'(fill_en), 32'h0);
        tick();
        mem_ready = 1'b0; mem_write = 1'b0;
        settle();
        chk("st_resume_frz", 32'(frz_vec()), 32'h00);
        chk("st_resume_fill", 32'(fill_en), 32'h0);
        chk("st_cnt", 32'(stall_count), 32'd10);
        tick();

        // load-use hazard on rs, then rt, then the r0 exemption
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        settle();
        chk("lu_rs", 32'(frz_vec()), 32'h11);
        tick();
        ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9;
        settle();
        chk("lu_rt", 32'(frz_vec()), 32'h11);
        tick();
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        settle();
        chk("lu_r0", 32'(frz_vec()), 32'h00);
        chk("lu_cnt", 32'(stall_count), 32'd10);
        tick();

        // miss concurrent with load-use: no bubble while the pipe is frozen; then timeout retry
        ex_rt = 5'd8; id_rs = 5'd8; mem_read = 1'b1; cache_hit = 1'b0;
        settle();
        chk("to_lu_frz", 32'(frz_vec()), 32'h1E);
        tick();
        ex_mem_read = 1'b0; mem_gnt = 1'b1;
        settle();
        chk("to_req", 32'(mem_req), 32'h1);
        tick();
        mem_gnt = 1'b0;
        tick();
        tick();
        tick();
        settle();
        chk("to_w4_err", 32'(timeout_err), 32'h0);
        chk("to_w4_req", 32'(mem_req), 32'h0);
        tick();
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_retry_req", 32'(mem_req), 32'h1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; cache_hit = 1'b1;
        settle();
        chk("to_fill", 32'(fill_en), 32'h1);
        tick();
        chk("to_resume_frz", 32'(frz_vec()), 32'h00);
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        chk("to_cnt", 32'(stall_count), 32'd19);
        mem_read = 1'b0; cache_hit = 1'b0;
        tick();

        // asynchronous reset in the middle of a read wait
        mem_read = 1'b1; mem_gnt = 1'b1;
        tick();
        tick();
        mem_gnt = 1'b0;
        tick();
        chk("ar_pre_frz", 32'(frz_vec()), 32'h1E);
        rst_b = 1'b0;
        settle();
        chk("ar_frz", 32'(frz_vec()), 32'h00);
        chk("ar_req", 32'(mem_req), 32'h0);
        chk("ar_fill", 32'(fill_en), 32'h0);
        chk("ar_cnt", 32'(stall_count), 32'h0);
        chk("ar_err", 32'(timeout_err), 32'h0);
        tick();
        rst_b = 1'b1;
        settle();
        chk("ar_idle_frz", 32'(frz_vec()), 32'h1E);
        chk("ar_idle_req", 32'(mem_req), 32'h0);
        tick();
        chk("ar_rereq", 32'(mem_req), 32'h1);
        mem_read = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
